// File: rtl/map_probe_scheduler_pkg.sv
// Shared constants, encodings and payload types for the map ROM probe scheduler.
package map_probe_scheduler_pkg;

  localparam int unsigned MAP_LU_X  = 150;
  localparam int unsigned MAP_LU_Y  = 50;
  localparam int unsigned MAP_W     = 347;
  localparam int unsigned MAP_H     = 405;
  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned PROBE_OFS = 12;

  localparam int unsigned XW = 11;      // scan coordinate width
  localparam int unsigned AW = 9;       // map address width
  localparam int unsigned PW = AW + 1;  // widened sum for the upper bound checks

  localparam logic [1:0] WALL_CODE = 2'b00;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_U = 2'd1,
    DIR_R = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [AW-1:0] x;
    logic [AW-1:0] y;
  } map_addr_t;

  // One blocked bit per direction slot of a packed {D,R,U,L} flag word.
  function automatic logic [3:0] wall_of(input logic [7:0] f);
    logic [3:0] w;
    for (int i = 0; i < 4; i++) begin
      w[i] = (f[2*i +: 2] == WALL_CODE);
    end
    return w;
  endfunction

endpackage

// File: rtl/map_probe_scheduler_probe_addr_gen.sv
// Maps the latched pacman centre and a direction index to a neighbour map address.
module map_probe_scheduler_probe_addr_gen
  import map_probe_scheduler_pkg::*;
(
  input  map_addr_t pos,
  input  dir_e      dir,
  output map_addr_t addr,
  output logic      out_of_map
);

  logic [PW-1:0] x_plus;
  logic [PW-1:0] y_plus;

  assign x_plus = {1'b0, pos.x} + PW'(PROBE_OFS);
  assign y_plus = {1'b0, pos.y} + PW'(PROBE_OFS);

  // The address may wrap when out of map; the caller overrides the data then.
  always_comb begin
    addr       = pos;
    out_of_map = 1'b0;
    case (dir)
      DIR_L: begin
        addr.x     = pos.x - AW'(PROBE_OFS);
        out_of_map = (pos.x < AW'(PROBE_OFS));
      end
      DIR_U: begin
        addr.y     = pos.y - AW'(PROBE_OFS);
        out_of_map = (pos.y < AW'(PROBE_OFS));
      end
      DIR_R: begin
        addr.x     = x_plus[AW-1:0];
        out_of_map = (x_plus >= PW'(MAP_W));
      end
      DIR_D: begin
        addr.y     = y_plus[AW-1:0];
        out_of_map = (y_plus >= PW'(MAP_H));
      end
    endcase
  end

endmodule

// File: rtl/map_probe_scheduler.sv
// Time-multiplexes one map ROM port between the VGA renderer and a four-neighbour
// wall probe that only borrows the port during blanking.
module map_probe_scheduler
  import map_probe_scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] vga_x,
  input  logic [XW-1:0] vga_y,
  input  logic          req,
  input  logic [AW-1:0] pos_x,
  input  logic [AW-1:0] pos_y,
  output logic [AW-1:0] rom_x,
  output logic [AW-1:0] rom_y,
  input  logic [1:0]    rom_pixel,
  output logic [1:0]    vga_pixel,
  output logic          busy,
  output logic          done,
  output logic [7:0]    flags,
  output logic [3:0]    wall
);

  state_e    state_q, state_d;
  dir_e      idx_q, idx_d;
  map_addr_t pos_q, pos_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] flags_q, flags_d;
  logic [3:0] wall_q, wall_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       blank;
  map_addr_t  probe_addr;
  logic       probe_oom;
  logic [1:0] probe_res;

  assign blank = (vga_x >= XW'(H_ACTIVE)) || (vga_y >= XW'(V_ACTIVE));

  map_probe_scheduler_probe_addr_gen u_addr_gen (
    .pos        (pos_q),
    .dir        (idx_q),
    .addr       (probe_addr),
    .out_of_map (probe_oom)
  );

  assign probe_res = probe_oom ? WALL_CODE : rom_pixel;

  // The probe owns the port only while blanking; otherwise the renderer does.
  always_comb begin
    if (state_q == ST_PROBE && blank) begin
      rom_x = probe_addr.x;
      rom_y = probe_addr.y;
    end else begin
      rom_x = AW'(vga_x - XW'(MAP_LU_X));
      rom_y = AW'(vga_y - XW'(MAP_LU_Y));
    end
  end

  assign vga_pixel = rom_pixel;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    shadow_d = shadow_q;
    flags_d  = flags_q;
    wall_d   = wall_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_PROBE;
          pos_d   = '{x: pos_x, y: pos_y};
          idx_d   = DIR_L;
          busy_d  = 1'b1;
        end
      end
      ST_PROBE: begin
        if (blank) begin
          shadow_d[{idx_q, 1'b0} +: 2] = probe_res;
          if (idx_q == DIR_D) begin
            state_d = ST_DONE;
            flags_d = shadow_d;
            wall_d  = wall_of(shadow_d);
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = dir_e'(idx_q + 2'd1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= DIR_L;
      pos_q    <= '0;
      shadow_q <= '0;
      flags_q  <= '0;
      wall_q   <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      shadow_q <= shadow_d;
      flags_q  <= flags_d;
      wall_q   <= wall_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign flags = flags_q;
  assign wall  = wall_q;

endmodule

// File: tb/tb_map_probe_scheduler.sv
// Randomized self-checking bench for map_probe_scheduler against a direct model
// of the probe geometry, bounds and blanking-only port sharing.
module tb_map_probe_scheduler;

  logic        clk;
  logic        reset;
  logic [10:0] vga_x;
  logic [10:0] vga_y;
  logic        req;
  logic [8:0]  pos_x;
  logic [8:0]  pos_y;
  logic [8:0]  rom_x;
  logic [8:0]  rom_y;
  logic [1:0]  rom_pixel;
  logic [1:0]  vga_pixel;
  logic        busy;
  logic        done;
  logic [7:0]  flags;
  logic [3:0]  wall;

  int         rom_mode;
  int         rom_seed;
  int         n_vec;
  int         n_err;
  logic [7:0] exp_flags;

  // ROM contents: 0 = single wall at (88,100), 1 = all path, 2 = hashed pattern.
  function automatic logic [1:0] rom_fn(input int x, input int y, input int mode, input int sd);
    if (mode == 0) return (x == 88 && y == 100) ? 2'b00 : 2'b01;
    if (mode == 1) return 2'b01;
    return 2'((x * 7 + y * 3 + sd) >> 1);
  endfunction

  function automatic logic [3:0] walls_from(input logic [7:0] f);
    logic [3:0] w;
    for (int i = 0; i < 4; i++) w[i] = (f[2*i +: 2] == 2'b00);
    return w;
  endfunction

  assign rom_pixel = rom_fn(int'(rom_x), int'(rom_y), rom_mode, rom_seed);

  map_probe_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .req       (req),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .rom_x     (rom_x),
    .rom_y     (rom_y),
    .rom_pixel (rom_pixel),
    .vga_pixel (vga_pixel),
    .busy      (busy),
    .done      (done),
    .flags     (flags),
    .wall      (wall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_blank();
    if ($urandom_range(0, 1) == 1) begin
      vga_x = 11'($urandom_range(640, 2047));
      vga_y = 11'($urandom_range(0, 2047));
    end else begin
      vga_x = 11'($urandom_range(0, 2047));
      vga_y = 11'($urandom_range(480, 2047));
    end
  endtask

  task automatic drive_active();
    vga_x = 11'($urandom_range(0, 639));
    vga_y = 11'($urandom_range(0, 479));
  endtask

  // One complete probe from IDLE: optional active-video pause before probe pause_at.
  task automatic do_probe(input logic [8:0] px, input logic [8:0] py, input int pause_at,
                          input int pause_len, input bit hold_req);
    int         dxo[4] = '{-12, 0, 12, 0};
    int         dyo[4] = '{0, -12, 0, 12};
    int         ex[4];
    int         ey[4];
    bit         oom[4];
    logic [7:0] nf;
    int         rx;
    int         ry;
    for (int i = 0; i < 4; i++) begin
      ex[i] = int'(px) + dxo[i];
      ey[i] = int'(py) + dyo[i];
      case (i)
        0: oom[i] = (ex[i] < 0);
        1: oom[i] = (ey[i] < 0);
        2: oom[i] = (ex[i] >= 347);
        default: oom[i] = (ey[i] >= 405);
      endcase
      nf[2*i +: 2] = oom[i] ? 2'b00 : rom_fn(ex[i] & 511, ey[i] & 511, rom_mode, rom_seed);
    end
    pos_x = px;
    pos_y = py;
    req   = 1'b1;
    if ($urandom_range(0, 1) == 1) drive_blank(); else drive_active();
    step();
    if (!hold_req) req = 1'b0;
    pos_x = 9'($urandom);
    pos_y = 9'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (i == pause_at) begin
        for (int c = 0; c < pause_len; c++) begin
          drive_active();
          #1;
          rx = (int'(vga_x) - 150) & 511;
          ry = (int'(vga_y) - 50) & 511;
          n_vec++;
          if (rom_x !== 9'(rx) || rom_y !== 9'(ry) || vga_pixel !== rom_fn(rx, ry, rom_mode, rom_seed)) begin
            n_err++;
            $display("FAIL pause_render idx%0d c%0d: rom=(%0d,%0d) pix=%0d required=(%0d,%0d) pix=%0d",
                     i, c, rom_x, rom_y, vga_pixel, rx, ry, rom_fn(rx, ry, rom_mode, rom_seed));
          end
          n_vec++;
          if (busy !== 1'b1 || done !== 1'b0 || flags !== exp_flags) begin
            n_err++;
            $display("FAIL pause_status idx%0d: busy=%b done=%b flags=%h required busy=1 done=0 flags=%h",
                     i, busy, done, flags, exp_flags);
          end
          step();
        end
      end
      drive_blank();
      #1;
      n_vec++;
      if (rom_x !== 9'(ex[i] & 511) || rom_y !== 9'(ey[i] & 511) || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL probe_addr idx%0d pos=(%0d,%0d): rom=(%0d,%0d) busy=%b done=%b required=(%0d,%0d) busy=1 done=0",
                 i, px, py, rom_x, rom_y, busy, done, ex[i] & 511, ey[i] & 511);
      end
      step();
    end
    exp_flags = nf;
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || flags !== exp_flags || wall !== walls_from(exp_flags)) begin
      n_err++;
      $display("FAIL done_cycle pos=(%0d,%0d): done=%b busy=%b flags=%h wall=%b required done=1 busy=0 flags=%h wall=%b",
               px, py, done, busy, flags, wall, exp_flags, walls_from(exp_flags));
    end
    drive_blank();
    step();
    req = 1'b0;
    #1;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || flags !== exp_flags) begin
      n_err++;
      $display("FAIL after_done: done=%b busy=%b flags=%h required done=0 busy=0 flags=%h",
               done, busy, flags, exp_flags);
    end
    step();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: done=%b busy=%b required done=0 busy=0", done, busy);
    end
  endtask

  task automatic test_reset();
    int rx;
    int ry;
    reset = 1'b1;
    req   = 1'b0;
    pos_x = '0;
    pos_y = '0;
    vga_x = 11'd700;
    vga_y = 11'd10;
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (flags !== 8'h00 || wall !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: flags=%h wall=%b busy=%b done=%b required 00 1111 0 0", flags, wall, busy, done);
    end
    repeat (3) step();
    reset = 1'b1;
    exp_flags = 8'h00;
    for (int c = 0; c < 3; c++) begin
      drive_blank();
      #1;
      rx = (int'(vga_x) - 150) & 511;
      ry = (int'(vga_y) - 50) & 511;
      n_vec++;
      if (rom_x !== 9'(rx) || rom_y !== 9'(ry) || busy !== 1'b0 || done !== 1'b0 || wall !== 4'b1111) begin
        n_err++;
        $display("FAIL reset_idle c%0d: rom=(%0d,%0d) busy=%b done=%b wall=%b required=(%0d,%0d) 0 0 1111",
                 c, rom_x, rom_y, busy, done, wall, rx, ry);
      end
      step();
    end
  endtask

  task automatic test_single_wall();
    rom_mode = 0;
    do_probe(9'd100, 9'd100, 4, 0, 1'b0);
    n_vec++;
    if (wall !== 4'b0001) begin
      n_err++;
      $display("FAIL single_wall: wall=%b required 0001", wall);
    end
  endtask

  task automatic test_active_start();
    rom_mode = 2;
    rom_seed = int'($urandom_range(0, 1000));
    do_probe(9'($urandom_range(20, 320)), 9'($urandom_range(20, 380)), 0, 5, 1'b0);
  endtask

  task automatic test_pause();
    logic [8:0] px;
    logic [8:0] py;
    rom_mode = 2;
    rom_seed = int'($urandom_range(0, 1000));
    px = 9'($urandom_range(0, 511));
    py = 9'($urandom_range(0, 511));
    do_probe(px, py, 4, 0, 1'b0);
    do_probe(px, py, 2, 10, 1'b0);
  endtask

  task automatic test_out_of_map();
    rom_mode = 1;
    do_probe(9'd5, 9'd400, 4, 0, 1'b0);
    n_vec++;
    if (flags !== 8'h14 || wall !== 4'b1001) begin
      n_err++;
      $display("FAIL oom_corner: flags=%h wall=%b required 14 1001", flags, wall);
    end
    do_probe(9'd340, 9'd5, 4, 0, 1'b0);
    rom_mode = 2;
    rom_seed = 17;
    do_probe(9'd12, 9'd392, 4, 0, 1'b0);
    do_probe(9'd11, 9'd393, 1, 2, 1'b0);
    do_probe(9'd334, 9'd12, 4, 0, 1'b0);
    do_probe(9'd335, 9'd11, 3, 3, 1'b0);
  endtask

  task automatic test_req_while_busy();
    rom_mode = 2;
    rom_seed = int'($urandom_range(0, 1000));
    do_probe(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 2, 2, 1'b1);
  endtask

  task automatic test_abort_reset();
    rom_mode = 1;
    do_probe(9'd200, 9'd200, 4, 0, 1'b0);
    pos_x = 9'd100;
    pos_y = 9'd100;
    req   = 1'b1;
    drive_blank();
    step();
    req = 1'b0;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    exp_flags = 8'h00;
    n_vec++;
    if (flags !== 8'h00 || wall !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: flags=%h wall=%b busy=%b done=%b required 00 1111 0 0", flags, wall, busy, done);
    end
    repeat (2) step();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive_blank();
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || flags !== 8'h00 ||
          rom_x !== 9'((int'(vga_x) - 150) & 511) || rom_y !== 9'((int'(vga_y) - 50) & 511)) begin
        n_err++;
        $display("FAIL abort_idle c%0d: busy=%b done=%b flags=%h rom=(%0d,%0d) required idle renderer address",
                 c, busy, done, flags, rom_x, rom_y);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++) begin
      rom_mode = 2;
      rom_seed = int'($urandom_range(0, 4000));
      do_probe(9'($urandom), 9'($urandom), int'($urandom_range(0, 5)),
               int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rom_mode  = 1;
    rom_seed  = 0;
    exp_flags = 8'h00;
    test_reset();
    test_single_wall();
    test_active_start();
    test_pause();
    test_out_of_map();
    test_req_while_busy();
    test_abort_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/map_probe_scheduler.md
Name: map_probe_scheduler

Overview:
- Shares one map ROM read port between two users: the VGA renderer (every visible pixel) and a wall-probe engine.
- On request, the probe engine reads the four neighbour map cells of the pacman centre, at offset PROBE_OFS left, up, right and down.
- Probe reads use only blanking cycles, so the renderer never loses a pixel.
- Replaces the four separate ROM instances of the direction-flag path with one time-multiplexed port.

Parameters:
- MAP_LU_X, 150, screen x of the map origin
- MAP_LU_Y, 50, screen y of the map origin
- MAP_W, 347, map width in pixels
- MAP_H, 405, map height in pixels
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- PROBE_OFS, 12, probe distance from the centre (half of the pacman width)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- vga_x  in  11  current scan column
- vga_y  in  11  current scan row
- req  in  1  start-probe strobe
- pos_x  in  9  pacman centre x, map coordinates
- pos_y  in  9  pacman centre y, map coordinates
- rom_x  out  9  map ROM x address
- rom_y  out  9  map ROM y address
- rom_pixel  in  2  map ROM data, combinational, same cycle; 2'b00 = wall
- vga_pixel  out  2  ROM data passed through to the renderer
- busy  out  1  probe in progress
- done  out  1  one-cycle pulse when results update
- flags  out  8  {D,R,U,L} ROM pixels, 2 bits each
- wall  out  4  {D,R,U,L}; 1 = blocked

Behaviour:
- Reset values (async, active-low): state IDLE; flags=8'h00; wall=4'b1111; busy=0; done=0; probe index 0.
- Blanking: blank = (vga_x >= H_ACTIVE) || (vga_y >= V_ACTIVE), combinational from the current inputs.
- ROM mux, combinational:
  - state PROBE and blank: rom_x/rom_y = probe address of the current index.
  - otherwise: rom_x = (vga_x - MAP_LU_X)[8:0], rom_y = (vga_y - MAP_LU_Y)[8:0].
  - vga_pixel = rom_pixel at all times.
- Probe order: index 0=L (x-OFS, y), 1=U (x, y-OFS), 2=R (x+OFS, y), 3=D (x, y+OFS). Addresses are computed from the latched position.
- FSM states: IDLE, PROBE, DONE.
  - IDLE: when req=1 at a clock edge, latch pos_x/pos_y, index=0, go to PROBE, busy=1.
  - PROBE: on each edge with blank=1, store the current index's result in a shadow register and increment the index. When blank=0, hold the index (pause) and resume at the next blank cycle. The edge that completes index 3 goes to DONE.
  - DONE: one cycle. flags/wall take the shadow values; done=1 and busy=0 during this cycle. Then go to IDLE.
- Latency: req accepted at edge k with continuous blanking gives probes at edges k+1..k+4 and done high in cycle k+5.
- Out-of-map probe: L with x<OFS, U with y<OFS, R with x+OFS>=MAP_W, D with y+OFS>=MAP_H.
  - Result forced to 2'b00 (wall); the probe still consumes its slot.
  - No ROM address substitution is needed; the forced value overrides rom_pixel.
- wall[i] = (flag_i == 2'b00).
- req while busy or in DONE: ignored; no queueing.
- flags/wall keep their previous values until the next done.
- Reset mid-probe: abort immediately, return to reset values; the partial shadow is discarded.
- Width rule: x+OFS is computed at 10 bits for the bound check; the subtraction bound check uses a compare, not a wrapped difference.

Decomposition:
- Shared package: MAP_LU_X/Y, MAP_W/H, H_ACTIVE/V_ACTIVE, wall code 2'b00, direction index encoding L=0 U=1 R=2 D=3, FSM state encoding.
- One natural sub-module: probe_addr_gen (combinational). Maps latched position + index to the address and an out_of_map flag.
- The ROM itself stays outside; the scheduler only drives its address.

Test Plan:
- Reset asserted mid-cycle (async) → flags=00, wall=1111, busy=0, done=0 immediately, without waiting for a clock edge.
- vga_x=700 constant, ROM model with wall only at (88,100); req with pos=(100,100) → rom addresses (88,100),(100,88),(112,100),(100,112) on cycles k+1..k+4; done in cycle k+5; wall=4'b0001.
- vga_x=200,vga_y=100 (active); req → rom_x=50, rom_y=50, busy=1, no probe address issued. After vga_x→640, probes complete and done follows 5 cycles later.
- Blank drops after 2 probes for 10 cycles, then returns → index held at 2, no address glitch toward the renderer, result identical to the uninterrupted run.
- pos=(5,400) → L and D forced wall regardless of ROM (all-path ROM model); U and R read from ROM.
- req pulsed at k+2 while busy → ignored, single done. reset deasserted→asserted at k+3 → no done, state IDLE.
